msk_frame_ctrl: RTL and testbench

Frame controller downstream of the MSK differential slicer/decoder. It takes the hard-bit stream (bit + 1-cycle valid) and hunts for a sync word, tolerating bit errors and the inverted-polarity ambiguity. After sync it reads a length byte, packs payload bits MSB-first into bytes and buffers them in a small FIFO with a valid/ready output. It also sequences frame start/abort/done and reports status to the upper-layer packet logic.

---
 rtl/msk_frame_ctrl.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_msk_frame_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/msk_frame_ctrl.sv
// msk_frame_ctrl: frame controller behind the MSK slicer/decoder.
// It hunts for a sync word in either polarity, tolerating up to MAX_ERR bit errors.
// It then reads a length byte and packs the payload MSB-first into a show-ahead byte FIFO.
// Optional CRC-16-CCITT check over the length and payload: define MSK_FRAME_CRC_EN.
// Without the macro there is no CRC state or logic, and crc_ok_o is tied high.
module msk_frame_ctrl #(
  parameter int          SYNC_W     = 32,
  parameter logic [31:0] SYNC_WORD  = 32'h1ACF_FC1D,
  parameter int          MAX_ERR    = 2,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable_i,
  input  logic       bit_i,
  input  logic       bit_valid_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       byte_last_o,
  input  logic       byte_ready_i,
  output logic       sync_det_o,
  output logic       inverted_o,
  output logic       frame_done_o,
  output logic       crc_ok_o,
  output logic       ovf_o,
  output logic [1:0] state_o
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [SYNC_W-1:0] SYNC_PAT = SYNC_WORD[SYNC_W-1:0];
  localparam logic [5:0]  MAX_ERR_C = 6'(MAX_ERR);
  localparam logic [5:0]  FILL_LAST = 6'(SYNC_W - 1);
  localparam logic [AW:0] DEPTH_C   = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {HUNT = 2'd0, LEN = 2'd1, PAYLOAD = 2'd2, CRC = 2'd3} state_t;

  // Number of differing bits between the shifted window and a reference pattern.
  function automatic logic [5:0] hamming(input logic [SYNC_W-1:0] a, input logic [SYNC_W-1:0] b);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < SYNC_W; i++) n = n + 6'(a[i] ^ b[i]);
    return n;
  endfunction

  // One serial step of CRC-16-CCITT (poly 0x1021), MSB first.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  state_t            state, state_n;
  logic [SYNC_W-1:0] sr, sr_n, sr_shift;
  logic [5:0]        fill_cnt, fill_n;
  logic              inv, inv_n;
  logic              sync_det, sync_det_n;
  logic [3:0]        bit_cnt, bit_cnt_n;
  logic [7:0]        shreg, shreg_n;
  logic [7:0]        byte_cnt, byte_cnt_n;
  logic              push_vld_p1, push_vld_n;
  logic [7:0]        push_byte_p1, push_byte_n;
  logic              push_last_p1, push_last_n;
  logic              ovf;
  logic              d;
  logic [5:0]        dist_true, dist_comp;

  logic [8:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              full, pop, push_go, push_ok, overflow;

`ifdef MSK_FRAME_CRC_EN
  logic [15:0]       crc, crc_n;
  logic [15:0]       rx_crc, rx_crc_n;
  logic              done_p1, done_n;
  logic              ok_p1, ok_n;
`endif

  assign d         = bit_i ^ inv;
  assign sr_shift  = {sr[SYNC_W-2:0], bit_i};
  assign dist_true = hamming(sr_shift, SYNC_PAT);
  assign dist_comp = hamming(sr_shift, ~SYNC_PAT);

  assign full     = (count == DEPTH_C);
  assign pop      = byte_valid_o & byte_ready_i;
  assign push_go  = push_vld_p1 & enable_i;
  assign push_ok  = push_go & (~full | pop);
  assign overflow = push_go & full & ~pop;

  // Next-state and datapath update: one bit is consumed by exactly one state.
  always_comb begin
    state_n     = state;
    sr_n        = bit_valid_i ? sr_shift : sr;
    fill_n      = fill_cnt;
    inv_n       = inv;
    sync_det_n  = 1'b0;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    byte_cnt_n  = byte_cnt;
    push_vld_n  = 1'b0;
    push_byte_n = push_byte_p1;
    push_last_n = push_last_p1;
`ifdef MSK_FRAME_CRC_EN
    crc_n       = crc;
    rx_crc_n    = rx_crc;
    done_n      = 1'b0;
    ok_n        = 1'b0;
`endif
    if (!enable_i) begin
      state_n   = HUNT;
      fill_n    = '0;
      bit_cnt_n = '0;
    end else if (overflow && state != HUNT) begin
      state_n   = HUNT;
      fill_n    = '0;
      bit_cnt_n = '0;
    end else begin
      case (state)
        HUNT: begin
          if (bit_valid_i) begin
            if (fill_cnt >= FILL_LAST) begin
              if (dist_true <= MAX_ERR_C || dist_comp <= MAX_ERR_C) begin
                inv_n      = (dist_true > MAX_ERR_C);
                sync_det_n = 1'b1;
                state_n    = LEN;
                bit_cnt_n  = '0;
`ifdef MSK_FRAME_CRC_EN
                crc_n      = 16'hFFFF;
`endif
              end
            end else begin
              fill_n = fill_cnt + 6'd1;
            end
          end
        end
        LEN: begin
          if (bit_valid_i) begin
            shreg_n   = {shreg[6:0], d};
            bit_cnt_n = bit_cnt + 4'd1;
`ifdef MSK_FRAME_CRC_EN
            crc_n     = crc_step(crc, d);
`endif
            if (bit_cnt == 4'd7) begin
              bit_cnt_n = '0;
              if (shreg_n == 8'd0) begin
                state_n = HUNT;
                fill_n  = '0;
              end else begin
                state_n    = PAYLOAD;
                byte_cnt_n = shreg_n;
              end
            end
          end
        end
        PAYLOAD: begin
          if (bit_valid_i) begin
            shreg_n   = {shreg[6:0], d};
            bit_cnt_n = bit_cnt + 4'd1;
`ifdef MSK_FRAME_CRC_EN
            crc_n     = crc_step(crc, d);
`endif
            if (bit_cnt == 4'd7) begin
              bit_cnt_n   = '0;
              push_vld_n  = 1'b1;
              push_byte_n = shreg_n;
              push_last_n = (byte_cnt == 8'd1);
              byte_cnt_n  = byte_cnt - 8'd1;
              if (byte_cnt == 8'd1) begin
`ifdef MSK_FRAME_CRC_EN
                state_n = CRC;
`else
                state_n = HUNT;
                fill_n  = '0;
`endif
              end
            end
          end
        end
`ifdef MSK_FRAME_CRC_EN
        CRC: begin
          if (bit_valid_i) begin
            rx_crc_n  = {rx_crc[14:0], d};
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              bit_cnt_n = '0;
              done_n    = 1'b1;
              ok_n      = (rx_crc_n == crc);
              state_n   = HUNT;
              fill_n    = '0;
            end
          end
        end
`endif
        default: begin
          state_n = HUNT;
          fill_n  = '0;
        end
      endcase
    end
  end

  // Stage p0 -> p1: FSM, sync window and completed-byte push request.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= HUNT;
      sr           <= '0;
      fill_cnt     <= '0;
      inv          <= 1'b0;
      sync_det     <= 1'b0;
      bit_cnt      <= '0;
      shreg        <= '0;
      byte_cnt     <= '0;
      push_vld_p1  <= 1'b0;
      push_byte_p1 <= '0;
      push_last_p1 <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      state        <= state_n;
      sr           <= sr_n;
      fill_cnt     <= fill_n;
      inv          <= inv_n;
      sync_det     <= sync_det_n;
      bit_cnt      <= bit_cnt_n;
      shreg        <= shreg_n;
      byte_cnt     <= byte_cnt_n;
      push_vld_p1  <= push_vld_n;
      push_byte_p1 <= push_byte_n;
      push_last_p1 <= push_last_n;
      if (overflow) ovf <= 1'b1;
    end
  end

`ifdef MSK_FRAME_CRC_EN
  // CRC accumulator, received CRC and end-of-frame verdict.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      crc     <= 16'hFFFF;
      rx_crc  <= '0;
      done_p1 <= 1'b0;
      ok_p1   <= 1'b0;
    end else begin
      crc     <= crc_n;
      rx_crc  <= rx_crc_n;
      done_p1 <= done_n & ~overflow;
      ok_p1   <= ok_n & ~overflow;
    end
  end
  assign frame_done_o = done_p1;
  assign crc_ok_o     = ok_p1;
`else
  assign frame_done_o = push_ok & push_last_p1;
  assign crc_ok_o     = 1'b1;
`endif

  // FIFO storage write; payload data needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {push_last_p1, push_byte_p1};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign byte_valid_o = (count != '0);
  assign byte_o       = byte_valid_o ? mem[rd_ptr][7:0] : 8'd0;
  assign byte_last_o  = byte_valid_o ? mem[rd_ptr][8] : 1'b0;
  assign sync_det_o   = sync_det;
  assign inverted_o   = inv;
  assign ovf_o        = ovf;
  assign state_o      = state;

endmodule

// File: tb/tb_msk_frame_ctrl.sv
// Scoreboard bench for msk_frame_ctrl: expected bytes are queued as frames are driven
// and compared as the FIFO hands them out. Frame events are counted per cycle.
module tb_msk_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset_n, enable_i, bit_i, bit_valid_i, byte_ready_i;
  logic [7:0] byte_o;
  logic       byte_valid_o, byte_last_o, sync_det_o, inverted_o;
  logic       frame_done_o, crc_ok_o, ovf_o;
  logic [1:0] state_o;

  int         n_checks = 0;
  int         n_errors = 0;
  int         sync_cnt = 0;
  int         done_cnt = 0;
  logic       last_crc_ok = 1'b0;
  logic [8:0] exp_q[$];
  logic [7:0] pay[0:31];
  logic [31:0] sync_word = 32'h1ACFFC1D;
  int         s0, d0;

  msk_frame_ctrl dut (
    .clk(clk), .reset_n(reset_n), .enable_i(enable_i), .bit_i(bit_i),
    .bit_valid_i(bit_valid_i), .byte_o(byte_o), .byte_valid_o(byte_valid_o),
    .byte_last_o(byte_last_o), .byte_ready_i(byte_ready_i), .sync_det_o(sync_det_o),
    .inverted_o(inverted_o), .frame_done_o(frame_done_o), .crc_ok_o(crc_ok_o),
    .ovf_o(ovf_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs on the falling edge, then step past the rising edge.
  task automatic tick();
    logic [8:0] e;
    @(negedge clk);
    if (sync_det_o) sync_cnt++;
    if (frame_done_o) begin
      done_cnt++;
      last_crc_ok = crc_ok_o;
    end
    if (byte_valid_o && byte_ready_i) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", {23'd0, byte_last_o, byte_o}, 32'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("sb_byte", {23'd0, byte_last_o, byte_o}, {23'd0, e});
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] crc16(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  task automatic send_bit(input logic b);
    bit_i = b;
    bit_valid_i = 1'b1;
    tick();
    bit_valid_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_sync(input logic inv, input logic [31:0] err);
    logic [31:0] sw;
    sw = sync_word ^ err;
    for (int i = 31; i >= 0; i--) send_bit(sw[i] ^ inv);
  endtask

  // Full frame: sync, length, payload (first n_exp bytes expected), CRC if built in.
  task automatic send_frame(input logic inv, input logic [31:0] err, input int len,
                            input int n_exp, input logic flip_crc);
    logic [15:0] c;
    logic [7:0]  lb;
    lb = 8'(len);
    send_sync(inv, err);
    c = crc16(16'hFFFF, lb);
    send_byte(lb ^ {8{inv}});
    for (int k = 0; k < len; k++) begin
      if (k < n_exp) exp_q.push_back({(k == len - 1), pay[k]});
      c = crc16(c, pay[k]);
      send_byte(pay[k] ^ {8{inv}});
    end
`ifdef MSK_FRAME_CRC_EN
    if (flip_crc) c[5] = ~c[5];
    for (int i = 15; i >= 0; i--) send_bit(c[i] ^ inv);
`else
    if (flip_crc) c[0] = ~c[0];
`endif
  endtask

  task automatic rehunt();
    enable_i = 1'b0;
    tick();
    enable_i = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset_n = 1'b0; enable_i = 1'b0; bit_i = 1'b0; bit_valid_i = 1'b0; byte_ready_i = 1'b1;
    idle(3);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_valid", 32'(byte_valid_o), 32'd0);
    check("rst_byte", 32'(byte_o), 32'd0);
    check("rst_flags", {27'd0, sync_det_o, inverted_o, frame_done_o, ovf_o, byte_last_o}, 32'd0);
`ifdef MSK_FRAME_CRC_EN
    check("rst_crc_ok", 32'(crc_ok_o), 32'd0);
`else
    check("rst_crc_ok", 32'(crc_ok_o), 32'd1);
`endif
    reset_n = 1'b1;
    enable_i = 1'b1;
    idle(2);

    // Normal polarity frame after random noise
    pay[0] = 8'hA5; pay[1] = 8'h3C; pay[2] = 8'h0F;
    s0 = sync_cnt; d0 = done_cnt;
    for (int i = 0; i < 40; i++) send_bit(1'($urandom_range(1, 0)));
    send_frame(1'b0, 32'd0, 3, 3, 1'b0);
    idle(6);
    check("norm_sync", 32'(sync_cnt - s0), 32'd1);
    check("norm_done", 32'(done_cnt - d0), 32'd1);
    check("norm_inv", 32'(inverted_o), 32'd0);
    check("norm_crc_ok", 32'(last_crc_ok), 32'd1);
    check("norm_drain", 32'(exp_q.size()), 32'd0);
    check("norm_state", 32'(state_o), 32'd0);

    // Inverted frame
    rehunt();
    s0 = sync_cnt; d0 = done_cnt;
    send_frame(1'b1, 32'd0, 3, 3, 1'b0);
    idle(6);
    check("inv_sync", 32'(sync_cnt - s0), 32'd1);
    check("inv_done", 32'(done_cnt - d0), 32'd1);
    check("inv_flag", 32'(inverted_o), 32'd1);
    check("inv_drain", 32'(exp_q.size()), 32'd0);

    // Two sync errors accepted
    rehunt();
    s0 = sync_cnt; d0 = done_cnt;
    pay[0] = 8'h5A; pay[1] = 8'hC3;
    send_frame(1'b0, 32'h0010_0008, 2, 2, 1'b0);
    idle(6);
    check("err2_sync", 32'(sync_cnt - s0), 32'd1);
    check("err2_done", 32'(done_cnt - d0), 32'd1);
    check("err2_inv", 32'(inverted_o), 32'd0);
    check("err2_drain", 32'(exp_q.size()), 32'd0);

    // Three sync errors rejected
    rehunt();
    s0 = sync_cnt;
    send_sync(1'b0, 32'h8001_0004);
    idle(3);
    check("err3_sync", 32'(sync_cnt - s0), 32'd0);
    check("err3_state", 32'(state_o), 32'd0);

    // Enable drop mid-payload after 2 of 4 bytes
    rehunt();
    s0 = sync_cnt; d0 = done_cnt;
    pay[0] = 8'h11; pay[1] = 8'h22;
    send_sync(1'b0, 32'd0);
    send_byte(8'd4);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back({1'b0, pay[k]});
      send_byte(pay[k]);
    end
    idle(2);
    check("dis_pre_state", 32'(state_o), 32'd2);
    enable_i = 1'b0;
    tick();
    check("dis_state", 32'(state_o), 32'd0);
    idle(6);
    check("dis_done", 32'(done_cnt - d0), 32'd0);
    check("dis_drain", 32'(exp_q.size()), 32'd0);
    enable_i = 1'b1;
    tick();
    pay[0] = 8'h44; pay[1] = 8'h55; pay[2] = 8'h66; pay[3] = 8'h77;
    send_frame(1'b0, 32'd0, 4, 4, 1'b0);
    idle(6);
    check("reen_sync", 32'(sync_cnt - s0), 32'd2);
    check("reen_done", 32'(done_cnt - d0), 32'd1);
    check("reen_drain", 32'(exp_q.size()), 32'd0);

`ifdef MSK_FRAME_CRC_EN
    // CRC good and bad
    rehunt();
    d0 = done_cnt;
    pay[0] = 8'h31;
    send_frame(1'b0, 32'd0, 1, 1, 1'b0);
    idle(4);
    check("crc_good_done", 32'(done_cnt - d0), 32'd1);
    check("crc_good_ok", 32'(last_crc_ok), 32'd1);
    rehunt();
    d0 = done_cnt;
    send_frame(1'b0, 32'd0, 1, 1, 1'b1);
    idle(4);
    check("crc_bad_done", 32'(done_cnt - d0), 32'd1);
    check("crc_bad_ok", 32'(last_crc_ok), 32'd0);
    check("crc_bad_drain", 32'(exp_q.size()), 32'd0);
`endif

    // Overflow: 20-byte frame into a 16-deep FIFO with the sink stalled
    rehunt();
    s0 = sync_cnt; d0 = done_cnt;
    for (int k = 0; k < 20; k++) pay[k] = 8'(k * 13 + 7);
    byte_ready_i = 1'b0;
    send_frame(1'b0, 32'd0, 20, 16, 1'b0);
    idle(4);
    check("ovf_flag", 32'(ovf_o), 32'd1);
    check("ovf_state", 32'(state_o), 32'd0);
    check("ovf_done", 32'(done_cnt - d0), 32'd0);
    check("ovf_sync", 32'(sync_cnt - s0), 32'd1);
    check("ovf_valid", 32'(byte_valid_o), 32'd1);
    byte_ready_i = 1'b1;
    idle(24);
    check("ovf_drain", 32'(exp_q.size()), 32'd0);
    check("ovf_empty", 32'(byte_valid_o), 32'd0);
    check("ovf_sticky", 32'(ovf_o), 32'd1);

    // Reset clears the sticky overflow
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    tick();
    check("ovf_cleared", 32'(ovf_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
